// File: rtl/obj_pkg.sv
// Shared definitions for the sprite motion engine: FSM state encoding,
// screen geometry, default off-screen margin and the signed velocity /
// extended position types also used by the spawn and collision logic.
package obj_pkg;

  localparam int POS_W_DEF      = 10;
  localparam int VEL_W_DEF      = 8;
  localparam int SCREEN_X_MAX   = 639;
  localparam int SCREEN_Y_MAX   = 479;
  localparam int DEFAULT_MARGIN = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FLY  = 2'd1,
    ST_EXIT = 2'd2
  } obj_state_e;

  // Signed velocity and position with two extra bits for off-screen travel.
  typedef logic signed [VEL_W_DEF-1:0] vel_t;
  typedef logic signed [POS_W_DEF+1:0] pos_ext_t;

endpackage

// File: rtl/sat_add_signed.sv
// Signed saturating adder: y = clamp(a + b, -2^(W-1), MAX).
// The upper bound is a parameter so it can act as a terminal-velocity clamp.
module sat_add_signed #(
  parameter int W   = 8,
  parameter int MAX = 127
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);

  localparam logic signed [W:0] HI_C = (W+1)'(MAX);
  localparam logic signed [W:0] LO_C = (W+1)'(-(2**(W-1)));

  logic signed [W:0] sum_s;

  // One extra bit holds the true sum so the clamp never sees a wrapped value.
  always_comb begin
    sum_s = $signed({a[W-1], a}) + $signed({b[W-1], b});
    if (sum_s > HI_C) begin
      y = HI_C[W-1:0];
    end else if (sum_s < LO_C) begin
      y = LO_C[W-1:0];
    end else begin
      y = sum_s[W-1:0];
    end
  end

endmodule

// File: rtl/object_kinematics.sv
// Per-sprite 2-D motion engine: launch load, per-tick position step with
// gravity and terminal-velocity clamp, off-screen retirement with a done pulse.
// Optional build macro BOUNCE_WALL_EN: side walls reflect the object instead
// of retiring it; only the bottom edge then retires.
module object_kinematics
  import obj_pkg::*;
#(
  parameter int POS_W  = POS_W_DEF,
  parameter int VEL_W  = VEL_W_DEF,
  parameter int GRAV   = 1,
  parameter int VMAX   = 15,
  parameter int X_MAX  = SCREEN_X_MAX,
  parameter int Y_MAX  = SCREEN_Y_MAX,
  parameter int MARGIN = DEFAULT_MARGIN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             moveclk,
  input  logic             launch,
  input  logic [POS_W-1:0] initPosX,
  input  logic [POS_W-1:0] initPosY,
  input  logic [VEL_W-1:0] initVx,
  input  logic [VEL_W-1:0] initVy,
  output logic [POS_W-1:0] posx,
  output logic [POS_W-1:0] posy,
  output logic             active,
  output logic             done
);

  localparam int PW = POS_W + 2;

  localparam logic signed [PW-1:0]    Y_HI_C  = PW'(Y_MAX + MARGIN);
  localparam logic signed [VEL_W-1:0] GRAV_C  = VEL_W'(GRAV);
  localparam logic signed [VEL_W-1:0] VZERO_C = '0;
`ifdef BOUNCE_WALL_EN
  localparam logic signed [PW-1:0]    PZERO_C = '0;
  localparam logic signed [PW-1:0]    X_MAX_C = PW'(X_MAX);
  localparam logic signed [PW-1:0]    X_DBL_C = PW'(2 * X_MAX);
`else
  localparam logic signed [PW-1:0]    X_LO_C  = PW'(-MARGIN);
  localparam logic signed [PW-1:0]    X_HI_C  = PW'(X_MAX + MARGIN);
`endif

  obj_state_e              state_r;
  logic signed [PW-1:0]    px_r;
  logic signed [PW-1:0]    py_r;
  logic signed [VEL_W-1:0] vx_r;
  logic signed [VEL_W-1:0] vy_r;
  logic                    active_r;
  logic                    done_r;

  logic signed [PW-1:0]    px_step_s;
  logic signed [PW-1:0]    py_step_s;
  logic signed [PW-1:0]    px_new_s;
  logic signed [VEL_W-1:0] vx_new_s;
  logic signed [VEL_W-1:0] vy_sat_s;
  logic                    exit_s;

  // Next vy: gravity added, clamped at terminal velocity, never wrapping.
  sat_add_signed #(
    .W   (VEL_W),
    .MAX (VMAX)
  ) u_vy_sat (
    .a (vy_r),
    .b (GRAV_C),
    .y (vy_sat_s)
  );

  // Candidate next position from the current velocities, plus exit decision.
  always_comb begin
    px_step_s = px_r + $signed({{(PW-VEL_W){vx_r[VEL_W-1]}}, vx_r});
    py_step_s = py_r + $signed({{(PW-VEL_W){vy_r[VEL_W-1]}}, vy_r});
`ifdef BOUNCE_WALL_EN
    if (px_step_s < PZERO_C) begin
      px_new_s = -px_step_s;
      vx_new_s = -vx_r;
    end else if (px_step_s > X_MAX_C) begin
      px_new_s = X_DBL_C - px_step_s;
      vx_new_s = -vx_r;
    end else begin
      px_new_s = px_step_s;
      vx_new_s = vx_r;
    end
    exit_s = (py_step_s > Y_HI_C) && (vy_sat_s > VZERO_C);
`else
    px_new_s = px_step_s;
    vx_new_s = vx_r;
    exit_s   = (px_step_s < X_LO_C) || (px_step_s > X_HI_C) ||
               ((py_step_s > Y_HI_C) && (vy_sat_s > VZERO_C));
`endif
  end

  // Flight FSM with registered position, velocity, active and done.
  // EXIT always returns to IDLE after one cycle so done stays a single pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      px_r     <= '0;
      py_r     <= '0;
      vx_r     <= '0;
      vy_r     <= '0;
      active_r <= 1'b0;
      done_r   <= 1'b0;
    end else if (launch) begin
      state_r  <= ST_FLY;
      px_r     <= $signed({2'b00, initPosX});
      py_r     <= $signed({2'b00, initPosY});
      vx_r     <= initVx;
      vy_r     <= initVy;
      active_r <= 1'b1;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
        end
        ST_FLY: begin
          if (en && moveclk) begin
            px_r <= px_new_s;
            py_r <= py_step_s;
            vx_r <= vx_new_s;
            vy_r <= vy_sat_s;
            if (exit_s) begin
              state_r  <= ST_EXIT;
              active_r <= 1'b0;
              done_r   <= 1'b1;
            end else begin
              state_r <= ST_FLY;
            end
          end else begin
            state_r <= ST_FLY;
          end
        end
        ST_EXIT: begin
          state_r  <= ST_IDLE;
          active_r <= 1'b0;
          done_r   <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          active_r <= 1'b0;
          done_r   <= 1'b0;
        end
      endcase
    end
  end

  assign posx   = px_r[POS_W-1:0];
  assign posy   = py_r[POS_W-1:0];
  assign active = active_r;
  assign done   = done_r;

endmodule

// File: tb/tb_object_kinematics.sv
// Self-checking bench for object_kinematics: directed scenarios with constant
// expectations plus a randomized run against an integer reference model.
module tb_object_kinematics;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       moveclk = 1'b0;
  logic       launch = 1'b0;
  logic [9:0] initPosX = 10'd0;
  logic [9:0] initPosY = 10'd0;
  logic [7:0] initVx = 8'd0;
  logic [7:0] initVy = 8'd0;
  logic [9:0] posx;
  logic [9:0] posy;
  logic       active;
  logic       done;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integers, flight phase implied by active/done.
  int m_px = 0, m_py = 0, m_vx = 0, m_vy = 0;
  bit m_active = 1'b0, m_done = 1'b0;

  object_kinematics dut (
    .clk(clk), .rst(rst), .en(en), .moveclk(moveclk), .launch(launch),
    .initPosX(initPosX), .initPosY(initPosY), .initVx(initVx), .initVy(initVy),
    .posx(posx), .posy(posy), .active(active), .done(done)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input bit r, input bit l, input bit m, input bit e);
    if (r) begin
      m_px = 0; m_py = 0; m_vx = 0; m_vy = 0; m_active = 0; m_done = 0;
    end else if (l) begin
      m_px = int'(initPosX); m_py = int'(initPosY);
      m_vx = int'($signed(initVx)); m_vy = int'($signed(initVy));
      m_active = 1; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_active && m && e) begin
      bit gone;
      m_px = m_px + m_vx;
      m_py = m_py + m_vy;
      m_vy = (m_vy + 1 > 15) ? 15 : m_vy + 1;
`ifdef BOUNCE_WALL_EN
      if (m_px < 0) begin m_px = -m_px; m_vx = -m_vx; end
      else if (m_px > 639) begin m_px = 1278 - m_px; m_vx = -m_vx; end
      gone = (m_py > 495) && (m_vy > 0);
`else
      gone = (m_px < -16) || (m_px > 655) || ((m_py > 495) && (m_vy > 0));
`endif
      if (gone) begin m_active = 0; m_done = 1; end
    end
  endtask

  task automatic step(input bit r, input bit l, input bit m, input bit e);
    rst = r; launch = l; moveclk = m; en = e;
    @(posedge clk);
    model_edge(r, l, m, e);
    #1;
    rst = 1'b0; launch = 1'b0; moveclk = 1'b0; en = 1'b1;
  endtask

  task automatic load(input int x, input int y, input int vx, input int vy);
    initPosX = 10'(x); initPosY = 10'(y); initVx = 8'(vx); initVy = 8'(vy);
  endtask

  task automatic tick();
    step(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (posx !== 10'd0 || posy !== 10'd0 || active !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: got x=%0d y=%0d act=%b done=%b, want 0 0 0 0", posx, posy, active, done);
    end
  endtask

  task automatic test_apex();
    load(100, 479, 3, -12);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (posx !== 10'd100 || posy !== 10'd479 || active !== 1'b1) begin
      errors++;
      $display("FAIL apex_load: got x=%0d y=%0d act=%b, want 100 479 1", posx, posy, active);
    end
    tick();
    checks++;
    if (posx !== 10'd103 || posy !== 10'd467) begin
      errors++;
      $display("FAIL apex_tick1: got x=%0d y=%0d, want 103 467", posx, posy);
    end
    for (int i = 0; i < 11; i++) tick();
    checks++;
    if (posx !== 10'd136 || posy !== 10'd401 || active !== 1'b1) begin
      errors++;
      $display("FAIL apex_top: got x=%0d y=%0d act=%b, want 136 401 1", posx, posy, active);
    end
    tick();
    checks++;
    if (posx !== 10'd139 || posy !== 10'd401) begin
      errors++;
      $display("FAIL apex_vy0: got x=%0d y=%0d, want 139 401", posx, posy);
    end
  endtask

  task automatic test_terminal();
    load(320, 0, 0, 14);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    checks++;
    if (posy !== 10'd14) begin
      errors++;
      $display("FAIL term_t1: got y=%0d, want 14", posy);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (posy !== 10'(29 + 15 * i)) begin
        errors++;
        $display("FAIL term_clamp: got y=%0d, want %0d", posy, 29 + 15 * i);
      end
    end
  endtask

  task automatic test_bottom_exit();
    load(300, 470, 0, 12);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    checks++;
    if (posy !== 10'd495 || done !== 1'b0 || active !== 1'b1) begin
      errors++;
      $display("FAIL exit_495: got y=%0d done=%b act=%b, want 495 0 1", posy, done, active);
    end
    tick();
    checks++;
    if (posy !== 10'd509 || done !== 1'b1 || active !== 1'b0) begin
      errors++;
      $display("FAIL exit_509: got y=%0d done=%b act=%b, want 509 1 0", posy, done, active);
    end
    tick();
    checks++;
    if (done !== 1'b0 || active !== 1'b0) begin
      errors++;
      $display("FAIL exit_pulse: got done=%b act=%b, want 0 0", done, active);
    end
  endtask

  task automatic test_launch_tick();
    load(300, 490, 0, 10);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    load(50, 60, 5, -3);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (posx !== 10'd50 || posy !== 10'd60 || done !== 1'b0) begin
      errors++;
      $display("FAIL launch_wins: got x=%0d y=%0d done=%b, want 50 60 0", posx, posy, done);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || active !== 1'b1) begin
        errors++;
        $display("FAIL relaunch_nodone: got done=%b act=%b, want 0 1", done, active);
      end
    end
    checks++;
    if (posx !== 10'd80 || posy !== 10'd57) begin
      errors++;
      $display("FAIL relaunch_pos: got x=%0d y=%0d, want 80 57", posx, posy);
    end
  endtask

  task automatic test_pause();
    load(200, 200, 2, -5);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (posx !== 10'd200 || posy !== 10'd200 || active !== 1'b1) begin
      errors++;
      $display("FAIL pause: got x=%0d y=%0d act=%b, want 200 200 1", posx, posy, active);
    end
    tick();
    checks++;
    if (posx !== 10'd202 || posy !== 10'd195) begin
      errors++;
      $display("FAIL pause_resume: got x=%0d y=%0d, want 202 195", posx, posy);
    end
  endtask

  task automatic test_rst_mid();
    load(300, 480, 0, 15);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    step(1'b1, 1'b0, 1'b1, 1'b1);
    checks++;
    if (posx !== 10'd0 || posy !== 10'd0 || active !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got x=%0d y=%0d act=%b done=%b, want 0 0 0 0", posx, posy, active, done);
    end
  endtask

  task automatic test_side_wall();
    load(637, 200, 5, 0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    tick();
`ifdef BOUNCE_WALL_EN
    checks++;
    if (posx !== 10'd636 || active !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL bounce: got x=%0d act=%b done=%b, want 636 1 0", posx, active, done);
    end
    tick();
    checks++;
    if (posx !== 10'd631) begin
      errors++;
      $display("FAIL bounce_vx: got x=%0d, want 631", posx);
    end
`else
    tick();
    tick();
    checks++;
    if (posx !== 10'd652 || active !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL side_652: got x=%0d act=%b done=%b, want 652 1 0", posx, active, done);
    end
    tick();
    checks++;
    if (posx !== 10'd657 || active !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL side_exit: got x=%0d act=%b done=%b, want 657 0 1", posx, active, done);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      bit r, l, m, e;
      r = ($urandom_range(499) == 0);
      l = m_active ? ($urandom_range(149) == 0) : ($urandom_range(3) == 0);
      m = $urandom_range(1) == 1;
      e = $urandom_range(7) != 0;
      load(int'($urandom_range(639)), int'($urandom_range(479)),
           int'($urandom_range(40)) - 20, int'($urandom_range(60)) - 40);
      step(r, l, m, e);
      checks++;
      if (active !== m_active || done !== m_done) begin
        errors++;
        $display("FAIL rand_status cyc %0d: got act=%b done=%b, want %b %b", i, active, done, m_active, m_done);
      end
      if (m_active || m_done) begin
        checks++;
        if (posx !== 10'(m_px) || posy !== 10'(m_py)) begin
          errors++;
          $display("FAIL rand_pos cyc %0d: got x=%0d y=%0d, want %0d %0d", i, posx, posy, 10'(m_px), 10'(m_py));
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_apex();
    test_terminal();
    test_bottom_exit();
    test_launch_tick();
    test_pause();
    test_rst_mid();
    test_side_wall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
